// File: rtl/arbitro_cajero.sv
// Round-robin session arbiter sharing one cajero transaction core between N_TERM card terminals.
// Grants one terminal per session, muxes its datapath to the core, and resets the core between sessions.
module arbitro_cajero #(
    parameter int N_TERM  = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [N_TERM-1:0]      REQ,
    input  logic [N_TERM-1:0]      TIPO_TRANS_IN,
    input  logic [4*N_TERM-1:0]    DIGITO_IN,
    input  logic [N_TERM-1:0]      DIGITO_STB_IN,
    input  logic [N_TERM-1:0]      MONTO_STB_IN,
    input  logic [32*N_TERM-1:0]   MONTO_IN,
    input  logic                   BALANCE_ACTUALIZADO,
    input  logic                   ENTREGAR_DINERO,
    input  logic                   FONDOS_INSUFICIENTES,
    input  logic                   BLOQUEO,
    output logic                   TARJETA_RECIBIDA,
    output logic                   TIPO_TRANS,
    output logic                   DIGITO_STB,
    output logic                   MONTO_STB,
    output logic [3:0]             DIGITO,
    output logic [31:0]            MONTO,
    output logic                   CAJERO_RST,
    output logic [N_TERM-1:0]      GNT,
    output logic [N_TERM-1:0]      FIN,
    output logic                   EXPIRADO,
    output logic [N_TERM-1:0]      BLOQ
);

    localparam int IW = $clog2(N_TERM);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        SESION  = 2'd2,
        LIBERAR = 2'd3
    } estado_t;

    estado_t         state;
    estado_t         next_state;
    logic [IW-1:0]   ult;
    logic [IW-1:0]   gidx;
    logic [CW-1:0]   cnt;

    logic [N_TERM-1:0] elig;
    logic              found;
    logic [IW-1:0]     sel_idx;
    logic [IW-1:0]     cand_idx;
    int                cand;
    logic              stb_g;
    logic              cierre;
    logic              cierre_exp;
    logic              cierre_bloq;
    logic              activo;
    logic              en_sesion;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Round-robin search starting one past the last granted terminal.
    always_comb begin
        elig     = REQ & ~BLOQ;
        found    = 1'b0;
        sel_idx  = '0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 1; k <= N_TERM; k++) begin
            cand     = (int'(ult) + k) % N_TERM;
            cand_idx = IW'(cand);
            if (!found && elig[cand_idx]) begin
                found   = 1'b1;
                sel_idx = cand_idx;
            end
        end
    end

    always_comb begin
        next_state  = state;
        cierre      = 1'b0;
        cierre_exp  = 1'b0;
        cierre_bloq = 1'b0;
        activo      = (state == GRANT) || (state == SESION);
        en_sesion   = (state == SESION);
        stb_g       = DIGITO_STB_IN[gidx] | MONTO_STB_IN[gidx];

        case (state)
            IDLE:    if (found) next_state = GRANT;
            GRANT:   next_state = SESION;
            SESION: begin
                // A strobe arriving as the counter tops out keeps the session alive.
                if (BLOQUEO) begin
                    cierre      = 1'b1;
                    cierre_bloq = 1'b1;
                end else if (BALANCE_ACTUALIZADO | ENTREGAR_DINERO | FONDOS_INSUFICIENTES) begin
                    cierre = 1'b1;
                end else if (!REQ[gidx]) begin
                    cierre = 1'b1;
                end else if ((cnt == CNT_MAX) && !stb_g) begin
                    cierre     = 1'b1;
                    cierre_exp = 1'b1;
                end
                if (cierre) next_state = LIBERAR;
            end
            LIBERAR: next_state = IDLE;
            default: next_state = IDLE;
        endcase

        TARJETA_RECIBIDA = activo;
        TIPO_TRANS       = activo & TIPO_TRANS_IN[gidx];
        DIGITO_STB       = en_sesion & DIGITO_STB_IN[gidx];
        MONTO_STB        = en_sesion & MONTO_STB_IN[gidx];
        DIGITO           = en_sesion ? DIGITO_IN[{gidx, 2'b00} +: 4] : 4'd0;
        MONTO            = en_sesion ? MONTO_IN[{gidx, 5'b00000} +: 32] : 32'd0;
        CAJERO_RST       = Reset & (state != LIBERAR);
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            GNT      <= '0;
            FIN      <= '0;
            EXPIRADO <= 1'b0;
            BLOQ     <= '0;
            cnt      <= '0;
            ult      <= IW'(N_TERM - 1);
            gidx     <= '0;
        end else begin
            FIN      <= '0;
            EXPIRADO <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        GNT  <= N_TERM'(1) << sel_idx;
                        gidx <= sel_idx;
                        ult  <= sel_idx;
                    end
                end
                GRANT: cnt <= '0;
                SESION: begin
                    if (cierre) begin
                        GNT      <= '0;
                        FIN      <= GNT;
                        EXPIRADO <= cierre_exp;
                        if (cierre_bloq) BLOQ[gidx] <= 1'b1;
                    end else if (stb_g) begin
                        cnt <= '0;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
